// File: rtl/wb_trace_buffer_pkg.sv
// Shared widths for the writeback trace buffer and anything that unpacks its entries.
package wb_trace_buffer_pkg;

    function automatic int entryWidth(input int dataW, input int seqW);
        return 2 * dataW + seqW;
    endfunction

    localparam int TRACE_DEPTH   = 16;
    localparam int TRACE_DATA_W  = 32;
    localparam int TRACE_SEQ_W   = 16;
    localparam int TRACE_ENTRY_W = entryWidth(TRACE_DATA_W, TRACE_SEQ_W);

endpackage

// File: rtl/wb_trace_buffer_sync_fifo.sv
// Generic show-ahead FIFO: DEPTH x WIDTH storage, wrap-bit pointers, occupancy count.
module sync_fifo
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH = TRACE_DEPTH,
    parameter int WIDTH = TRACE_ENTRY_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wrData,
    output logic [WIDTH-1:0]         rdData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wPtr;
    logic [AW:0]      rPtr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush;
    logic             doPop;

    assign empty  = (wPtr == rPtr);
    assign full   = (wPtr[AW] != rPtr[AW]) && (wPtr[AW-1:0] == rPtr[AW-1:0]);
    assign count  = wPtr - rPtr;

    // A pop frees the slot in the same edge, so a full FIFO still takes a push.
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wPtr <= '0;
            rPtr <= '0;
        end else begin
            if (doPush) wPtr <= wPtr + 1'b1;
            if (doPop)  rPtr <= rPtr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) mem[wPtr[AW-1:0]] <= wrData;
    end

    assign rdData = mem[rPtr[AW-1:0]];

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures every writeback commit {pc, data, seq} into a FIFO and drains it over valid/ready.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH,
    parameter int DATA_W = TRACE_DATA_W,
    parameter int SEQ_W  = TRACE_SEQ_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_valid,
    input  logic [DATA_W-1:0]      wb_pc,
    input  logic [DATA_W-1:0]      wb_data,
    input  logic                   clear_ovf,
    input  logic                   rd_ready,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_pc,
    output logic [DATA_W-1:0]      rd_data,
    output logic [SEQ_W-1:0]       rd_seq,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [SEQ_W-1:0]       drop_cnt
);

    localparam int ENTRY_W = entryWidth(DATA_W, SEQ_W);

    logic [SEQ_W-1:0]   seqCnt;
    logic [ENTRY_W-1:0] wrEntry;
    logic [ENTRY_W-1:0] headEntry;
    logic               fifoFull;
    logic               fifoEmpty;
    logic               popReq;
    logic               dropNow;

    function automatic logic [SEQ_W-1:0] satInc(input logic [SEQ_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign wrEntry  = {wb_pc, wb_data, seqCnt};
    assign rd_valid = !fifoEmpty;
    assign popReq   = rd_valid && rd_ready;
    assign dropNow  = wb_valid && fifoFull && !popReq;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (wb_valid),
        .pop    (rd_ready),
        .wrData (wrEntry),
        .rdData (headEntry),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .count  (count)
    );

    // Storage is never reset, so the head is masked whenever nothing valid is held.
    assign rd_pc   = rd_valid ? headEntry[ENTRY_W-1 -: DATA_W] : '0;
    assign rd_data = rd_valid ? headEntry[SEQ_W +: DATA_W]     : '0;
    assign rd_seq  = rd_valid ? headEntry[SEQ_W-1:0]           : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seqCnt   <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (wb_valid) seqCnt <= seqCnt + 1'b1;
            // A drop coinciding with a clear must stay visible.
            if (dropNow) begin
                overflow <= 1'b1;
                drop_cnt <= clear_ovf ? SEQ_W'(1) : satInc(drop_cnt);
            end else if (clear_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule
